// File: rtl/fp_mult_arbiter.sv
// Round-robin arbiter sharing one pipelined fp_mult between NUM_REQ requesters.
// Latency: PIPE_STAGES cycles from grant to rsp_valid, plus stall cycles.
// Backpressure: a refused response freezes the multiplier and the tag pipeline, and blocks new grants.
//
// Ports:
//   clk, resetn            clock, synchronous active-low reset
//   req_valid/req_ready    per-requester request handshake; operands in req_a/req_b/req_round slices
//   rsp_valid/rsp_ready    per-requester response handshake; rsp_z/rsp_status shared and qualified by rsp_valid
//   mult_a/b/round/en      drive the shared multiplier; mult_z/mult_status come back from it
//   inflight               number of valid entries in the tag pipeline
module fp_mult_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int SIG_W       = 23,
  parameter int EX_W        = 8,
  parameter int PIPE_STAGES = 2,
  localparam int DATA_W     = SIG_W + EX_W + 1,
  localparam int TAG_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  input  logic [NUM_REQ*3-1:0]      req_round,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]         rsp_z,
  output logic [7:0]                rsp_status,
  output logic [DATA_W-1:0]         mult_a,
  output logic [DATA_W-1:0]         mult_b,
  output logic [2:0]                mult_round,
  output logic                      mult_en,
  input  logic [DATA_W-1:0]         mult_z,
  input  logic [7:0]                mult_status,
  output logic [2:0]                inflight
);

  logic               stall;
  logic [NUM_REQ-1:0] elig;
  logic               grant_any;
  logic [TAG_W-1:0]   grant_idx;
  logic [TAG_W-1:0]   rr_ptr;
  logic [TAG_W-1:0]   last_idx;
  logic [TAG_W-1:0]   sel_idx;
  logic               out_vld;
  logic [TAG_W-1:0]   out_tag;
  logic               rsp_hs;

  // Output slot and stall source depend on whether the multiplier is registered.
  generate
    if (PIPE_STAGES == 0) begin : g_comb
      // Combinational multiplier: the result leaves in the grant cycle, so only
      // requesters able to take it right now are eligible, and nothing can stall.
      assign elig    = req_valid & rsp_ready;
      assign stall   = 1'b0;
      assign out_vld = grant_any;
      assign out_tag = grant_idx;
    end else begin : g_pipe
      logic             tag_vld [PIPE_STAGES];
      logic [TAG_W-1:0] tag_idx [PIPE_STAGES];

      assign elig    = req_valid;
      assign out_vld = tag_vld[PIPE_STAGES-1];
      assign out_tag = tag_idx[PIPE_STAGES-1];
      assign stall   = out_vld & ~rsp_ready[out_tag];

      // Tag pipeline mirrors the multiplier's register stages and moves with mult_en,
      // so bubbles (vld=0) advance too.
      always_ff @(posedge clk) begin
        if (!resetn) begin
          for (int k = 0; k < PIPE_STAGES; k++) begin
            tag_vld[k] <= 1'b0;
            tag_idx[k] <= '0;
          end
        end else if (mult_en) begin
          tag_vld[0] <= grant_any;
          tag_idx[0] <= grant_idx;
          for (int k = 1; k < PIPE_STAGES; k++) begin
            tag_vld[k] <= tag_vld[k-1];
            tag_idx[k] <= tag_idx[k-1];
          end
        end
      end
    end
  endgenerate

  assign mult_en = resetn & ~stall;

  // Round-robin search starting at rr_ptr; first eligible requester wins.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    if (resetn && !stall) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!grant_any && elig[(int'(rr_ptr) + k) % NUM_REQ]) begin
          grant_any = 1'b1;
          grant_idx = TAG_W'((int'(rr_ptr) + k) % NUM_REQ);
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (grant_any) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  // Without a grant the operand mux parks on the last granted requester, keeping
  // multiplier inputs quiet instead of toggling with whatever slice index 0 holds.
  assign sel_idx    = grant_any ? grant_idx : last_idx;
  assign mult_a     = req_a[int'(sel_idx)*DATA_W +: DATA_W];
  assign mult_b     = req_b[int'(sel_idx)*DATA_W +: DATA_W];
  assign mult_round = req_round[int'(sel_idx)*3 +: 3];

  always_comb begin
    rsp_valid = '0;
    if (resetn && out_vld) begin
      rsp_valid[out_tag] = 1'b1;
    end
  end

  assign rsp_z      = mult_z;
  assign rsp_status = mult_status;
  assign rsp_hs     = resetn & out_vld & rsp_ready[out_tag];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rr_ptr   <= '0;
      last_idx <= '0;
      inflight <= '0;
    end else begin
      if (grant_any) begin
        rr_ptr   <= (grant_idx == TAG_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
        last_idx <= grant_idx;
      end
      case ({grant_any, rsp_hs})
        2'b10:   inflight <= inflight + 3'd1;
        2'b01:   inflight <= inflight - 3'd1;
        default: inflight <= inflight;
      endcase
    end
  end

endmodule

// File: doc/fp_mult_arbiter.md
Name: fp_mult_arbiter

Overview:
- Shares one pipelined fp_mult instance between NUM_REQ requesters using round-robin arbitration.
- Each requester has a valid/ready request channel (operands and rounding mode) and a valid/ready response channel (product and status).
- The block drives the multiplier's operand, round and enable inputs, and tracks an in-flight requester tag alongside each pipeline stage.
- Each result is routed back to the requester that issued it; the whole pipeline is stalled when that requester's response is not accepted.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- SIG_W, 23, significand width of the shared multiplier.
- EX_W, 8, exponent width of the shared multiplier.
- PIPE_STAGES, 2, register stages inside the shared multiplier (0..3); must match the instance.
- Derived: DATA_W = SIG_W+EX_W+1; TAG_W = max(1, clog2(NUM_REQ)).

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester request accepted (one-hot or zero).
- req_a  in  NUM_REQ*DATA_W  operand a; requester i uses slice i.
- req_b  in  NUM_REQ*DATA_W  operand b; requester i uses slice i.
- req_round  in  NUM_REQ*3  rounding mode; requester i uses slice i.
- rsp_valid  out  NUM_REQ  per-requester result valid (one-hot or zero).
- rsp_ready  in  NUM_REQ  per-requester result accept.
- rsp_z  out  DATA_W  product, shared by all requesters, qualified by rsp_valid.
- rsp_status  out  8  multiplier status flags, shared, qualified by rsp_valid.
- mult_a  out  DATA_W  to multiplier input a.
- mult_b  out  DATA_W  to multiplier input b.
- mult_round  out  3  to multiplier round input.
- mult_en  out  1  to multiplier enable.
- mult_z  in  DATA_W  from multiplier output z.
- mult_status  in  8  from multiplier status.
- inflight  out  3  number of valid operations in the tag pipeline.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-low, resetn. All state updates on the rising edge of clk.
- Reset values: rr_ptr=0; all tag valids=0; inflight=0; req_ready=0; rsp_valid=0.
- Reset forces mult_en=0.
- Reset mid-operation discards every in-flight result; no rsp_valid is issued for it afterwards.
- Tag pipeline: PIPE_STAGES entries of {vld, tag}, stage k fed from stage k-1. Stage 1 is fed from the issue slot: {grant_any, grant_idx}.
- The tag pipeline advances only when mult_en=1.
- Output slot, PIPE_STAGES>=1: the last tag stage.
- stall = out_vld & ~rsp_ready[out_tag].
- mult_en = ~stall while out of reset. It is 1 even with no grant, so that bubbles advance.
- rsp_valid[out_tag] = out_vld.
- rsp_z = mult_z and rsp_status = mult_status, driven combinationally.
- A result is held stable while rsp_valid=1 and rsp_ready=0.
- Arbitration: when stall=0, grant the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
- req_ready = onehot(grant). The mult_a/b/round mux selects the granted requester; when there is no grant the mux holds the last-granted slice.
- On a grant, rr_ptr <= grant_idx+1, wrapping to 0. With no grant, rr_ptr holds.
- No grant is made while stall=1.
- PIPE_STAGES=0: the multiplier is combinational.
  - Eligibility is req_valid[i] & rsp_ready[i].
  - rsp_valid = req_ready, in the same cycle.
  - stall is always 0 and the tag stages are absent.
- Latency: an operation accepted in cycle t shows rsp_valid in cycle t+PIPE_STAGES plus the number of stall cycles.
- Throughput: one operation per cycle when rsp_ready is held at all ones.
- inflight: incremented on a grant, decremented on a response handshake, unchanged when both occur in the same cycle. Saturates at PIPE_STAGES by construction.
- Ordering: responses leave in issue order; per-requester order is preserved.
- A requester may have several operations in flight at once.
- Requests carry no ID; requesters rely on ordering alone.

Test Plan:
- Single request, PIPE_STAGES=2.
  - Stimulus: req 1 with a=0x40000000, b=0x40400000, round=0 (RNE), rsp_ready all ones.
  - Required: req_ready[1] high in cycle t; rsp_valid=4'b0010 in cycle t+2 with rsp_z=0x40C00000 and status=0.
- Round robin.
  - Stimulus: all four req_valid held high, rsp_ready all ones.
  - Required: grant sequence 0,1,2,3,0,1; one rsp_valid per cycle from cycle 2, in that same order.
- Backpressure.
  - Stimulus: requester 2 issues 0x3FC00000*0x3FC00000 with rsp_ready[2]=0 for 3 cycles; requester 0 requests continuously.
  - Required: rsp_valid[2] held with rsp_z=0x40100000 for 4 cycles; mult_en=0 and no grants during the stall; rsp_z stable.
- Pointer fairness.
  - Stimulus: only req 3 valid, then req 0 and req 3 valid together.
  - Required: grant 3, then grant 0 (rr_ptr wrapped to 0), then grant 3.
- Reset mid-operation.
  - Stimulus: two operations in flight, resetn=0 for 1 cycle.
  - Required: rsp_valid=0, inflight=0 and rr_ptr=0 after reset; the discarded results never appear on rsp_valid.
- PIPE_STAGES=0.
  - Stimulus: req 1 valid with rsp_ready[1]=0, req 2 valid with rsp_ready[2]=1.
  - Required: req 2 granted, rsp_valid[2] in the same cycle; req 1 not granted until rsp_ready[1]=1.
